// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - serial bit stream handshake between source and detector
interface seq_det_ctrl_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - session controller for overlapping serial pattern detection
module seq_det_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int BUDW   = 16,
    localparam int LENW  = $clog2(MAXLEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic [BUDW-1:0]   cfg_budget,
    seq_det_ctrl_if.slave     stream,
    output logic              busy,
    output logic              match,
    output logic [CNTW-1:0]   match_count,
    output logic              done,
    output logic              hit,
    output logic              cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [LENW:0] MAXLEN_L = (LENW + 1)'(MAXLEN);

    state_t            state;
    logic [MAXLEN-1:0] pattern_r;
    logic [LENW-1:0]   len_r;
    logic [CNTW-1:0]   target_r;
    logic [BUDW-1:0]   budget_r;
    logic [MAXLEN-1:0] history;
    logic [LENW-1:0]   fill;
    logic [BUDW-1:0]   bits_seen;

    logic              cfg_bad;
    logic              accept;
    logic [MAXLEN-1:0] history_new;
    logic [MAXLEN-1:0] len_mask;
    logic [LENW:0]     fill_p1;
    logic              fill_full;
    logic [LENW-1:0]   fill_next;
    logic [BUDW-1:0]   bits_seen_new;
    logic              match_now;
    logic [CNTW-1:0]   count_new;
    logic              target_reached;
    logic              budget_reached;

    assign busy             = (state == ST_RUN);
    assign stream.bit_ready = (state == ST_RUN);

    assign cfg_bad = (cfg_len == '0) || ({1'b0, cfg_len} > MAXLEN_L) || (cfg_target == '0);
    assign accept  = stream.bit_valid && (state == ST_RUN);

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            len_mask[i] = (i < int'(len_r));
        end
    end

    // fill saturates at len, so fill_full means the window already holds len bits including this one
    assign history_new   = {history[MAXLEN-2:0], stream.bit_in};
    assign fill_p1       = {1'b0, fill} + {{LENW{1'b0}}, 1'b1};
    assign fill_full     = (fill_p1 >= {1'b0, len_r});
    assign fill_next     = fill_full ? len_r : fill_p1[LENW-1:0];
    assign bits_seen_new = bits_seen + {{(BUDW-1){1'b0}}, 1'b1};
    assign match_now     = fill_full && (((history_new ^ pattern_r) & len_mask) == '0);
    assign count_new     = match_count + {{(CNTW-1){1'b0}}, match_now};
    assign target_reached = (count_new == target_r);
    assign budget_reached = (budget_r != '0) && (bits_seen_new == budget_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            pattern_r   <= '0;
            len_r       <= '0;
            target_r    <= '0;
            budget_r    <= '0;
            history     <= '0;
            fill        <= '0;
            bits_seen   <= '0;
            match_count <= '0;
            match       <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pattern_r <= cfg_pattern;
                        len_r     <= cfg_len;
                        target_r  <= cfg_target;
                        budget_r  <= cfg_budget;
                        hit       <= 1'b0;
                        if (cfg_bad) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end else begin
                            state       <= ST_RUN;
                            history     <= '0;
                            fill        <= '0;
                            bits_seen   <= '0;
                            match_count <= '0;
                            cfg_err     <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    // abort wins over any bit offered on the same edge
                    if (abort) begin
                        state <= ST_IDLE;
                        hit   <= 1'b0;
                    end else if (accept) begin
                        history     <= history_new;
                        fill        <= fill_next;
                        bits_seen   <= bits_seen_new;
                        match       <= match_now;
                        match_count <= count_new;
                        if (target_reached) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            hit   <= 1'b1;
                        end else if (budget_reached) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            hit   <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic [7:0] cfg_target;
    logic [15:0] cfg_budget;
    logic       busy;
    logic       match;
    logic [7:0] match_count;
    logic       done;
    logic       hit;
    logic       cfg_err;

    seq_det_ctrl_if sif ();

    seq_det_ctrl #(.MAXLEN(8), .CNTW(8), .BUDW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_target  (cfg_target),
        .cfg_budget  (cfg_budget),
        .stream      (sif.slave),
        .busy        (busy),
        .match       (match),
        .match_count (match_count),
        .done        (done),
        .hit         (hit),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: session flag plus the list of accepted bits of this session
    bit       m_active;
    bit       acc[$];
    int       m_count;
    bit       m_hit;
    bit       m_err;
    int       m_len;
    bit [7:0] m_pat;
    int       m_tgt;
    int       m_bud;

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [7:0]  tgt;
        logic [15:0] bud;
        int          nbits;
        logic [15:0] bits;
        logic [7:0]  exp_count;
        logic        exp_hit;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic v, input logic b, input logic ab);
        bit em;
        bit ed;
        int n;
        sif.bit_valid = v;
        sif.bit_in    = b;
        abort         = ab;
        chk("bit_ready", sif.bit_ready, m_active);
        chk("busy", busy, m_active);
        em = 0;
        ed = 0;
        if (m_active && ab) begin
            m_active = 0;
            m_hit    = 0;
        end else if (m_active && v) begin
            acc.push_back(b);
            n = acc.size();
            if (n >= m_len) begin
                em = 1;
                for (int i = 0; i < m_len; i++) begin
                    if (acc[n - m_len + i] != m_pat[m_len - 1 - i]) em = 0;
                end
            end
            if (em) m_count++;
            if (m_count == m_tgt) begin
                ed = 1; m_hit = 1; m_active = 0;
            end else if (m_bud != 0 && n == m_bud) begin
                ed = 1; m_hit = 0; m_active = 0;
            end
        end
        @(posedge clk);
        #1;
        sif.bit_valid = 1'b0;
        abort         = 1'b0;
        chk("match", match, em);
        chk("done", done, ed);
        chk("match_count", match_count, m_count);
        chk("hit", hit, m_hit);
    endtask

    task automatic do_start(input logic [7:0] pat, input logic [3:0] len,
                            input logic [7:0] tgt, input logic [15:0] bud);
        bit ok;
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_target    = tgt;
        cfg_budget    = bud;
        start         = 1'b1;
        sif.bit_valid = 1'b0;
        chk("start_ready_low", sif.bit_ready, 0);
        ok = (len != 0) && (len <= 8) && (tgt != 0);
        @(posedge clk);
        #1;
        start       = 1'b0;
        cfg_pattern = 8'($urandom);
        cfg_len     = 4'($urandom);
        cfg_target  = 8'($urandom);
        cfg_budget  = 16'($urandom);
        m_hit = 0;
        if (ok) begin
            acc.delete();
            m_count  = 0;
            m_err    = 0;
            m_active = 1;
            m_len    = int'(len);
            m_pat    = pat;
            m_tgt    = int'(tgt);
            m_bud    = int'(bud);
        end else begin
            m_err = 1;
        end
        chk("start_done", done, !ok);
        chk("cfg_err", cfg_err, m_err);
        chk("start_hit", hit, 0);
        chk("start_match", match, 0);
        chk("start_count", match_count, m_count);
        chk("start_busy", busy, ok);
        chk("start_ready", sif.bit_ready, ok);
        if (!ok) cycle(0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{8'b1011,     4'd4, 8'd2,  16'd0, 7, 16'b1011011,  8'd2, 1'b1};
        vecs[1] = '{8'b111,      4'd3, 8'd5,  16'd6, 6, 16'b111111,   8'd4, 1'b0};
        vecs[2] = '{8'b10,       4'd2, 8'd1,  16'd2, 2, 16'b10,       8'd1, 1'b1};
        vecs[3] = '{8'b1,        4'd1, 8'd3,  16'd0, 5, 16'b01011,    8'd3, 1'b1};
        vecs[4] = '{8'b10101010, 4'd8, 8'd1,  16'd0, 8, 16'b10101010, 8'd1, 1'b1};
        vecs[5] = '{8'b00,       4'd2, 8'd10, 16'd5, 5, 16'b00000,    8'd4, 1'b0};
        vecs[6] = '{8'hF5,       4'd3, 8'd2,  16'd0, 5, 16'b10101,    8'd2, 1'b1};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_target = '0; cfg_budget = '0;
        sif.bit_in = 1'b0; sif.bit_valid = 1'b0;
        m_active = 0; m_count = 0; m_hit = 0; m_err = 0;
        m_len = 1; m_pat = 0; m_tgt = 1; m_bud = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", sif.bit_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_count", match_count, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_cfg_err", cfg_err, 0);
        reset = 1'b0;
        cycle(0, 0, 0);

        for (int v = 0; v < 7; v++) begin
            do_start(vecs[v].pat, vecs[v].len, vecs[v].tgt, vecs[v].bud);
            for (int i = 0; i < vecs[v].nbits; i++) begin
                cycle(1, vecs[v].bits[vecs[v].nbits - 1 - i], 0);
            end
            cycle(1, 1, 0);
            chk($sformatf("vec%0d_count", v), match_count, vecs[v].exp_count);
            chk($sformatf("vec%0d_hit", v), hit, vecs[v].exp_hit);
            chk($sformatf("vec%0d_cfg_err", v), cfg_err, 0);
        end

        // gaps in bit_valid must not advance the window or the budget
        do_start(8'b1, 4'd1, 8'd100, 16'd4);
        for (int i = 0; i < 12; i++) cycle((i % 3) == 0, 1, 0);
        chk("toggle_count", match_count, 4);
        chk("toggle_hit", hit, 0);

        do_start(8'b1, 4'd0, 8'd1, 16'd0);
        chk("cfg_err_len0", cfg_err, 1);
        do_start(8'b1, 4'd9, 8'd1, 16'd0);
        chk("cfg_err_len9", cfg_err, 1);
        do_start(8'b1, 4'd1, 8'd0, 16'd0);
        chk("cfg_err_tgt0", cfg_err, 1);
        do_start(8'b1, 4'd1, 8'd1, 16'd0);
        chk("cfg_err_clear", cfg_err, 0);
        cycle(1, 1, 0);
        chk("after_err_hit", hit, 1);
        cycle(0, 0, 0);

        // abort with a would-be matching bit on the same edge
        do_start(8'b11, 4'd2, 8'd9, 16'd0);
        cycle(1, 1, 0); cycle(1, 1, 0); cycle(1, 1, 0);
        cycle(1, 1, 1);
        chk("abort_count", match_count, 2);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        do_start(8'b11, 4'd2, 8'd9, 16'd0);
        cycle(1, 1, 0);
        cycle(1, 1, 0);

        // asynchronous reset while match is high
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ready", sif.bit_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_match", match, 0);
        chk("arst_count", match_count, 0);
        chk("arst_done", done, 0);
        chk("arst_hit", hit, 0);
        chk("arst_cfg_err", cfg_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_active = 0; m_count = 0; m_hit = 0; m_err = 0;
        acc.delete();
        cycle(0, 0, 0);
        do_start(8'b11, 4'd2, 8'd9, 16'd0);
        cycle(1, 1, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);

        for (int s = 0; s < 40; s++) begin
            logic [3:0]  rl;
            logic [15:0] rb;
            rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(5, 8)) : 4'($urandom_range(1, 4));
            rb = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(3, 30));
            do_start(8'($urandom), rl, 8'($urandom_range(1, 4)), rb);
            for (int c = 0; c < 60 && m_active; c++) begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 0);
            end
            if (m_active) cycle(0, 0, 1);
            cycle(0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Session controller for serial-bit pattern detection. It accepts a runtime-programmable pattern (1..MAXLEN bits) and a start command, then streams bits through a valid/ready handshake. Matches are detected with overlap, counted, and the session terminates on a match-count target or a bit budget. It sits between the host/config logic and the serial input stream, and owns all detector sequencing.

Parameters:
MAXLEN, 8, maximum pattern length in bits
CNTW, 8, width of match counter and target
BUDW, 16, width of bit budget and bits-seen counter

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and clears all registers
start  in  1  session start pulse; sampled in IDLE only
abort  in  1  cancels an active session; sampled in RUN only
cfg_pattern  in  MAXLEN  pattern; bit cfg_len-1 is the earliest bit, bit 0 the latest
cfg_len  in  $clog2(MAXLEN+1)  pattern length; valid range 1..MAXLEN
cfg_target  in  CNTW  match count that ends the session; valid range >=1
cfg_budget  in  BUDW  maximum bits to accept; 0 = unlimited
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in is valid
bit_ready  out  1  controller accepts a bit this cycle
busy  out  1  session active (RUN)
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNTW  matches in the current or last session
done  out  1  one-cycle pulse at session end
hit  out  1  last session ended on target (1) or on budget (0); valid from done onward
cfg_err  out  1  last start carried invalid config

Behaviour:
- Reset: state IDLE; history, fill, bits_seen, match_count, match, done, hit, cfg_err, busy and bit_ready all 0.
- States: IDLE, RUN, DONE.
- IDLE: bit_ready=0, busy=0. On start=1, latch cfg_* into internal registers.
  - If cfg_len==0, cfg_len>MAXLEN or cfg_target==0: go to DONE with cfg_err=1 and hit=0.
  - Otherwise: go to RUN and clear history, fill, bits_seen, match_count, cfg_err and hit.
- RUN: busy=1, bit_ready=1 (both combinational from state). busy and bit_ready first assert in the cycle after the start edge.
- Acceptance: a bit is accepted when bit_valid & bit_ready. On each accepted bit:
  - history <= {history[MAXLEN-2:0], bit_in}.
  - fill <= min(fill+1, len).
  - bits_seen <= bits_seen+1.
- Match condition, evaluated on the accepting edge: (fill_before+1 >= len) and history_new[len-1:0] == pattern[len-1:0]. Overlapping matches count, e.g. 1011 on 1011011 yields 2 matches.
- match is registered: it pulses high for exactly one cycle after the accepting edge, and match_count increments on that same edge.
- Termination is evaluated on the accepting edge using the post-update values:
  - If match_count_new == target: go to DONE, hit=1.
  - Else if budget!=0 and bits_seen_new == budget: go to DONE, hit=0.
  - If both occur on the same bit, target wins (hit=1).
  - The terminating bit is the last bit accepted; bit_ready is low from the next cycle.
- abort=1 in RUN: go to IDLE on that edge. Any bit accepted in the same cycle is discarded (no match, no count). done does not pulse. match_count keeps its pre-abort value; hit=0.
- DONE: lasts exactly one cycle. done=1, bit_ready=0, busy=0. Then returns to IDLE.
- start is ignored in RUN and DONE. abort is ignored outside RUN.
- match_count, hit and cfg_err hold until the next valid start or reset.
- No overflow is possible: match_count stops at target (at most 2^CNTW-1). bits_seen wraps only when budget=0, and wrapping has no effect.
- Asynchronous reset mid-session returns to IDLE immediately. No done pulse is produced.

Test Plan:
- Pattern 4'b1011, len=4, target=2, budget=0; stream 1,0,1,1,0,1,1 with valid high -> match pulses after bits 4 and 7; done with hit=1, match_count=2; bit_ready low after bit 7.
- Pattern 3'b111, len=3, target=5, budget=6; six 1s -> 4 matches (bits 3-6); budget reached at bit 6 -> done, hit=0, match_count=4.
- Target and budget on the same bit: pattern 2'b10, target=1, budget=2; stream 1,0 -> done, hit=1.
- bit_valid toggling 1,0,0,1,... with pattern len=1 pattern=1 -> only valid cycles counted; idle cycles produce no match and leave bits_seen unchanged.
- Invalid config: cfg_len=0 or cfg_target=0 -> DONE the next cycle, cfg_err=1, done pulse, bit_ready never high. Then a valid start clears cfg_err.
- Abort after 3 bits, and async reset mid-RUN -> IDLE, no done pulse. For reset, all outputs are 0 immediately. For abort, match_count holds its value. A subsequent start begins with cleared history (no match from stale bits).
